regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the pipelined RV32 core. Succeeds the single-write, two-read register file.
- Adds:
  - NRP read ports with same-cycle write-to-read bypass
  - two prioritised writeback ports
  - a per-register busy scoreboard (set at issue, cleared at writeback)
  - registered ecall halt/print detection
- Sits between decode/issue (reads, issue marks) and writeback.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers (power of two, >=2).
- AW, $clog2(NREG), index width (derived; do not override).
- NRP, 2, number of read ports (>=2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous active-low reset.
- wb0_en  in  1  writeback port 0 valid.
- wb0_rd  in  AW  port 0 destination index.
- wb0_data  in  XLEN  port 0 write data.
- wb1_en  in  1  writeback port 1 valid (younger instruction).
- wb1_rd  in  AW  port 1 destination index.
- wb1_data  in  XLEN  port 1 write data.
- iss_en  in  1  issue marks a destination pending.
- iss_rd  in  AW  destination index being issued.
- rs_index  in  NRP*AW  packed read indices; port k at bits [k*AW +: AW].
- rs_data  out  NRP*XLEN  packed read data; port k at [k*XLEN +: XLEN].
- rs_busy  out  NRP  port k source register is pending (after this cycle's clears).
- ecall_sig  in  1  ecall instruction present this cycle.
- halt  out  1  sticky halt request.
- print_valid  out  1  one-cycle print request.
- print_data  out  XLEN  value of a2 (x12) captured with print_valid.

Behaviour:
- Reset, sampled on rising clk with reset==0:
  - all registers, busy bits, halt, print_valid and print_data go to 0.
  - Reset overrides every write, issue and ecall in that cycle, including mid-operation.
- Register 0:
  - reads always return 0; writes are dropped; never busy.
  - iss_rd==0 is ignored.
- Writes:
  - committed on the rising edge.
  - If wb0_rd==wb1_rd (nonzero) and both enables are high, wb1_data is stored (port 1 wins).
- Reads are combinational, with bypass priority:
  1. index 0 -> 0
  2. wb1 match -> wb1_data
  3. wb0 match -> wb0_data
  4. stored value
  - Zero-latency read-after-write within one cycle.
- Scoreboard, one busy bit per register:
  - Rising edge: a bit clears if its index matches an enabled wb port; it sets if iss_en && iss_rd==index.
  - Set and clear of the same index in the same cycle -> set wins (newer producer pending).
  - rs_busy[k] = busy[idx] && !(wb0 or wb1 matching idx this cycle), combinationally. Exception: if iss_en targets idx this cycle, rs_busy is still derived from current state only; the issue takes effect next cycle.
  - Writes to a non-busy register are legal and do not alter busy.
- Ecall, evaluated on the rising edge with ecall_sig==1, using bypassed values of a0 (x10), a1 (x11) and a2 (x12):
  - a0==0 && a1==0 -> halt=1 from next cycle, held until reset.
  - a0==0 && a1==1 -> print_valid=1 for exactly one cycle; print_data=a2.
  - Otherwise no effect. print_valid is 0 in every cycle not following such an ecall.
  - Once halt=1, further ecalls produce no print_valid; writes still update state.
- No internal FSM beyond the sticky halt bit. The block has no backpressure: the issue stage must stall on rs_busy.

Test Plan:
- Reset then read: assert reset=0 for 1 cycle with wb0_en=1, wb0_rd=5, wb0_data=0xDEAD -> x5 reads 0, all rs_busy=0, halt=0.
- Bypass and priority: wb0 (rd=7, 0x1111) and wb1 (rd=7, 0x2222) same cycle, rs_index port0=7 -> rs_data port0=0x2222 same cycle; next cycle x7=0x2222. Separately, wb0_rd=0 with data 0xFFFF -> x0 reads 0.
- Scoreboard: iss rd=3 -> next cycle rs_busy for x3=1. Then wb0 rd=3 with iss rd=3 same cycle -> busy stays 1. A later wb1 rd=3 alone -> rs_busy=0 that cycle (bypass), bit cleared next cycle.
- Print ecall: write x10=0, x11=1, x12=0x42, then ecall_sig=1 -> print_valid=1 for one cycle with print_data=0x42; halt stays 0.
- Halt with bypass: x10=0 stored; in the ecall cycle wb0 writes x11=0 -> halt=1 next cycle. It stays 1 through further ecalls until reset=0 clears it.
- Multi-port: NRP=4, all four ports read distinct registers 1..4 preloaded 0xA..0xD -> packed rs_data correct per slice.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port RV32 integer register file: NRP bypassed read ports, two prioritised
// writeback ports, per-register busy scoreboard and registered ecall halt/print detection.
module regfile_mp #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = $clog2(NREG),
   parameter int NRP  = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wb0_en,
   input  logic [AW-1:0]       wb0_rd,
   input  logic [XLEN-1:0]     wb0_data,
   input  logic                wb1_en,
   input  logic [AW-1:0]       wb1_rd,
   input  logic [XLEN-1:0]     wb1_data,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_rd,
   input  logic [NRP*AW-1:0]   rs_index,
   output logic [NRP*XLEN-1:0] rs_data,
   output logic [NRP-1:0]      rs_busy,
   input  logic                ecall_sig,
   output logic                halt,
   output logic                print_valid,
   output logic [XLEN-1:0]     print_data
);

   localparam logic [AW-1:0] A0_IDX = AW'(10);
   localparam logic [AW-1:0] A1_IDX = AW'(11);
   localparam logic [AW-1:0] A2_IDX = AW'(12);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic            halt_q;
   logic            print_valid_q;
   logic [XLEN-1:0] print_data_q;

   logic [XLEN-1:0] a0_s;
   logic [XLEN-1:0] a1_s;
   logic [XLEN-1:0] a2_s;
   logic            halt_hit_s;
   logic            print_hit_s;

   // An enabled port targeting a nonzero index; x0 is never written or tracked.
   function automatic logic hit(input logic en, input logic [AW-1:0] rd,
                                input logic [AW-1:0] idx);
      return en && (rd == idx) && (rd != '0);
   endfunction

   // Read value with same-cycle bypass: x0, then wb1 (younger), then wb0, then storage.
   function automatic logic [XLEN-1:0] byp(input logic [AW-1:0] idx);
      logic [XLEN-1:0] v;
      if (idx == '0)                         v = '0;
      else if (hit(wb1_en, wb1_rd, idx))     v = wb1_data;
      else if (hit(wb0_en, wb0_rd, idx))     v = wb0_data;
      else                                   v = regs_q[idx];
      return v;
   endfunction

   // Next register and busy state; port 1 wins on a shared destination, issue beats clear.
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         regs_d[i] = (i == 0)                         ? '0 :
                     hit(wb1_en, wb1_rd, AW'(i))      ? wb1_data :
                     hit(wb0_en, wb0_rd, AW'(i))      ? wb0_data : regs_q[i];
         busy_d[i] = (i != 0) &&
                     (hit(iss_en, iss_rd, AW'(i)) ||
                      (busy_q[i] && !hit(wb0_en, wb0_rd, AW'(i))
                                 && !hit(wb1_en, wb1_rd, AW'(i))));
      end
   end

   for (genvar k = 0; k < NRP; k++) begin : g_rd
      logic [AW-1:0] idx_s;
      assign idx_s                    = rs_index[k*AW +: AW];
      assign rs_data[k*XLEN +: XLEN]  = byp(idx_s);
      assign rs_busy[k]               = busy_q[idx_s] && !hit(wb0_en, wb0_rd, idx_s)
                                                      && !hit(wb1_en, wb1_rd, idx_s);
   end

   // Ecall decode on bypassed a0/a1/a2; a halted core no longer prints.
   always_comb begin
      a0_s        = byp(A0_IDX);
      a1_s        = byp(A1_IDX);
      a2_s        = byp(A2_IDX);
      halt_hit_s  = ecall_sig && (a0_s == '0) && (a1_s == '0);
      print_hit_s = ecall_sig && !halt_q && (a0_s == '0) && (a1_s == XLEN'(1));
   end

   // State update; synchronous active-low reset overrides all same-cycle activity.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
         busy_q        <= '0;
         halt_q        <= 1'b0;
         print_valid_q <= 1'b0;
         print_data_q  <= '0;
      end else begin
         regs_q        <= regs_d;
         busy_q        <= busy_d;
         halt_q        <= halt_q | halt_hit_s;
         print_valid_q <= print_hit_s;
         print_data_q  <= print_hit_s ? a2_s : print_data_q;
      end
   end

   assign halt        = halt_q;
   assign print_valid = print_valid_q;
   assign print_data  = print_data_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (NRP=4): expectations are queued as stimulus is driven
// and popped against DUT outputs at the following falling edge.
module tb_regfile_mp;
   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int NRP  = 4;

   localparam int K_DATA = 0, K_BUSY = 1, K_HALT = 2, K_PV = 3, K_PD = 4;

   logic                clk = 1'b0;
   logic                reset;
   logic                wb0_en, wb1_en, iss_en, ecall_sig;
   logic [AW-1:0]       wb0_rd, wb1_rd, iss_rd;
   logic [XLEN-1:0]     wb0_data, wb1_data;
   logic [NRP*AW-1:0]   rs_index;
   logic [NRP*XLEN-1:0] rs_data;
   logic [NRP-1:0]      rs_busy;
   logic                halt, print_valid;
   logic [XLEN-1:0]     print_data;

   typedef struct {
      string       tag;
      int          kind;
      int          port;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) dut (
      .clk(clk), .reset(reset),
      .wb0_en(wb0_en), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
      .wb1_en(wb1_en), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
      .iss_en(iss_en), .iss_rd(iss_rd),
      .rs_index(rs_index), .rs_data(rs_data), .rs_busy(rs_busy),
      .ecall_sig(ecall_sig), .halt(halt),
      .print_valid(print_valid), .print_data(print_data)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic push(input string tag, input int kind, input int port, input logic [31:0] val);
      exp_t e;
      e.tag = tag; e.kind = kind; e.port = port; e.val = val;
      exp_q.push_back(e);
   endtask

   // Pop and compare every queued expectation against the settled outputs.
   task automatic check_all();
      exp_t        e;
      logic [31:0] obs;
      @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         case (e.kind)
            K_DATA:  obs = rs_data[e.port*XLEN +: XLEN];
            K_BUSY:  obs = {31'd0, rs_busy[e.port]};
            K_HALT:  obs = {31'd0, halt};
            K_PV:    obs = {31'd0, print_valid};
            K_PD:    obs = print_data;
            default: obs = 32'hxxxx_xxxx;
         endcase
         check_eq(e.tag, obs, e.val);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wb0_en = 1'b0; wb0_rd = '0; wb0_data = '0;
      wb1_en = 1'b0; wb1_rd = '0; wb1_data = '0;
      iss_en = 1'b0; iss_rd = '0; ecall_sig = 1'b0;
   endtask

   task automatic set_rs(input int k, input int idx);
      rs_index[k*AW +: AW] = AW'(idx);
   endtask

   task automatic wb0(input int rd, input logic [31:0] d);
      wb0_en = 1'b1; wb0_rd = AW'(rd); wb0_data = d;
   endtask

   task automatic wb1(input int rd, input logic [31:0] d);
      wb1_en = 1'b1; wb1_rd = AW'(rd); wb1_data = d;
   endtask

   initial begin
      reset = 1'b0; rs_index = '0;
      idle();
      // Reset cycle with a competing write that must be dropped
      wb0(5, 32'hDEAD);
      step();
      reset = 1'b1; idle(); set_rs(0, 5);
      push("rst_x5", K_DATA, 0, 32'h0);
      for (int k = 0; k < NRP; k++) push($sformatf("rst_busy%0d", k), K_BUSY, k, 32'h0);
      push("rst_halt", K_HALT, 0, 32'h0);
      push("rst_pv", K_PV, 0, 32'h0);
      check_all();

      // Port 1 wins on a shared destination, visible the same cycle
      step(); wb0(7, 32'h1111); wb1(7, 32'h2222); set_rs(0, 7); set_rs(1, 7);
      push("byp_p1_win0", K_DATA, 0, 32'h2222);
      push("byp_p1_win1", K_DATA, 1, 32'h2222);
      check_all();
      step(); idle(); wb0(0, 32'hFFFF); set_rs(1, 0);
      push("x7_stored", K_DATA, 0, 32'h2222);
      push("x0_bypass", K_DATA, 1, 32'h0);
      check_all();
      step(); idle();
      push("x0_stored", K_DATA, 1, 32'h0);
      check_all();

      // Scoreboard
      step(); iss_en = 1'b1; iss_rd = AW'(3); set_rs(0, 3);
      push("busy_iss_same", K_BUSY, 0, 32'h0);
      check_all();
      step(); idle();
      push("busy_set", K_BUSY, 0, 32'h1);
      check_all();
      step(); wb0(3, 32'h33); iss_en = 1'b1; iss_rd = AW'(3);
      push("busy_clr_byp", K_BUSY, 0, 32'h0);
      push("x3_byp", K_DATA, 0, 32'h33);
      check_all();
      step(); idle();
      push("busy_set_wins", K_BUSY, 0, 32'h1);
      check_all();
      step(); wb1(3, 32'h44);
      push("busy_wb1_byp", K_BUSY, 0, 32'h0);
      check_all();
      step(); idle();
      push("busy_cleared", K_BUSY, 0, 32'h0);
      push("x3_stored", K_DATA, 0, 32'h44);
      check_all();

      // Print ecall
      step(); wb0(10, 32'h0); wb1(11, 32'h1);
      step(); idle(); wb0(12, 32'h42);
      step(); idle(); ecall_sig = 1'b1;
      push("pv_before", K_PV, 0, 32'h0);
      check_all();
      step(); idle();
      push("pv_pulse", K_PV, 0, 32'h1);
      push("pd_value", K_PD, 0, 32'h42);
      push("halt_print", K_HALT, 0, 32'h0);
      check_all();
      step();
      push("pv_one_cycle", K_PV, 0, 32'h0);
      check_all();

      // Halt with a0 stored and a1 bypassed to zero in the ecall cycle
      step(); ecall_sig = 1'b1; wb0(11, 32'h0);
      push("halt_not_yet", K_HALT, 0, 32'h0);
      check_all();
      step(); idle();
      push("halt_set", K_HALT, 0, 32'h1);
      push("pv_halt", K_PV, 0, 32'h0);
      check_all();
      step(); ecall_sig = 1'b1; wb0(11, 32'h1);
      step(); idle(); set_rs(2, 11);
      push("halt_sticky", K_HALT, 0, 32'h1);
      push("pv_after_halt", K_PV, 0, 32'h0);
      push("x11_after_halt", K_DATA, 2, 32'h1);
      check_all();
      step(); iss_en = 1'b1; iss_rd = AW'(9); reset = 1'b0;
      step(); reset = 1'b1; idle(); set_rs(0, 7); set_rs(1, 9);
      push("halt_cleared", K_HALT, 0, 32'h0);
      push("x7_reset", K_DATA, 0, 32'h0);
      push("busy9_reset", K_BUSY, 1, 32'h0);
      check_all();

      // Multi-port read of distinct registers
      step(); wb0(1, 32'hA); wb1(2, 32'hB);
      step(); idle(); wb0(3, 32'hC); wb1(4, 32'hD);
      step(); idle();
      for (int k = 0; k < NRP; k++) set_rs(k, k + 1);
      for (int k = 0; k < NRP; k++) push($sformatf("mp_port%0d", k), K_DATA, k, 32'hA + k);
      check_all();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
